cp15_sysctrl: RTL and testbench

Parametrised system-control coprocessor serving two requesters: CPU (MCR/MRC) and MMU (table-walk reads, fault-status writes).
- Holds NUM_REGS configuration registers and arbitrates between requesters with a round-robin req/ack handshake instead of a stall signal.
- Sequences cache and TLB maintenance operations through a done-handshake with the memory system.
- Sits beside the pipeline controller and MMU; drives control and tbase continuously.

---
 rtl/cp15_pkg.sv | 79 +++++++
 rtl/cp15_rr_arb.sv | 39 +++
 rtl/cp15_sysctrl.sv | 167 ++++++++++++++++
 tb/tb_cp15_sysctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp15_pkg.sv
// cp15_pkg -- shared types, register constants and maintenance decode for the
// CP15 system-control coprocessor.
//   maint_op_t     : {invi, invd, cleani, cleand, tlbi, tlbd}, MSB first
//   state_t        : maintenance sequencer states
//   CP15_RESET_VAL : per-register reset contents (r0..r15)
//   CP15_WMASK     : bits a write may change (r0, r7, r8 never change)
//   CP15_RMASK     : bits a read returns
//   decode_maint() : CPU write (op2, CRm, CRn) -> maintenance operation, 0 if none
package cp15_pkg;

   typedef struct packed {
      logic invi;
      logic invd;
      logic cleani;
      logic cleand;
      logic tlbi;
      logic tlbd;
   } maint_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAINT = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam int CTRL_REG  = 1;
   localparam int TBASE_REG = 2;
   localparam int CACHE_REG = 7;
   localparam int TLB_REG   = 8;

   localparam logic [31:0] CP15_RESET_VAL [16] = '{
      32'h41069265, 32'h00090070, 32'h00000000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h40000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

   // r7/r8 are operation triggers, not storage, so their write mask is empty.
   localparam logic [31:0] CP15_WMASK [16] = '{
      32'h00000000, 32'h0000FFFF, 32'hFFFFC000, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'h000001FF, 32'hFFFFFFFF, 32'h00000000,
      32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

   localparam logic [31:0] CP15_RMASK [16] = '{
      32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFC000, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'h000001FF, 32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

   function automatic maint_op_t decode_maint(input logic [2:0]  op2,
                                              input logic [3:0]  crm,
                                              input logic [31:0] crn);
      maint_op_t op;
      op = maint_op_t'(6'b000000);
      if (op2 <= 3'd1 && crn == 32'(CACHE_REG)) begin
         case (crm)
            4'b0111: op = maint_op_t'(6'b110000);
            4'b0101: op = maint_op_t'(6'b100000);
            4'b0110: op = maint_op_t'(6'b010000);
            4'b1011: op = maint_op_t'(6'b001100);
            4'b1010: op = maint_op_t'(6'b000100);
            4'b1111: op = maint_op_t'(6'b111100);
            4'b1110: op = maint_op_t'(6'b010100);
            default: op = maint_op_t'(6'b000000);
         endcase
      end else if (op2 <= 3'd1 && crn == 32'(TLB_REG)) begin
         case (crm)
            4'b0111: op = maint_op_t'(6'b000011);
            4'b0101: op = maint_op_t'(6'b000010);
            4'b0110: op = maint_op_t'(6'b000001);
            default: op = maint_op_t'(6'b000000);
         endcase
      end else begin
         op = maint_op_t'(6'b000000);
      end
      return op;
   endfunction

endpackage

// File: rtl/cp15_rr_arb.sv
// cp15_rr_arb -- two-requester round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset (pointer back to CPU)
//   en         : arbitration allowed this cycle
//   req[0]=CPU, req[1]=MMU ; gnt one-hot (or zero), combinational
// The priority pointer flips after every grant, whoever received it.
module cp15_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr;   // 0: CPU has priority, 1: MMU has priority

   // grant selection
   always_comb begin
      gnt = 2'b00;
      if (!en) begin
         gnt = 2'b00;
      end else if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

   // priority pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (|gnt) begin
         ptr <= ~ptr;
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/cp15_sysctrl.sv
// cp15_sysctrl -- system-control coprocessor shared by CPU and MMU.
//   cpu_req/we/addr/op2/crm/wdata -> cpu_ack, cpu_rdata : CPU MCR/MRC port
//   mmu_req/we/addr/wdata         -> mmu_ack, mmu_rdata : MMU port
//   maint_valid, maint_op, maint_done                   : maintenance handshake
//   control, tbase                                      : registered r1 / r2
// Build option CP15_MAINT_TIMEOUT_EN: abandon a maintenance op after 1024
// cycles without maint_done and flag it in r5 bit 0.
module cp15_sysctrl
   import cp15_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [2:0]        cpu_op2,
   input  logic [3:0]        cpu_crm,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              mmu_req,
   input  logic              mmu_we,
   input  logic [ADDR_W-1:0] mmu_addr,
   input  logic [DATA_W-1:0] mmu_wdata,
   output logic              mmu_ack,
   output logic [DATA_W-1:0] mmu_rdata,
   output logic              maint_valid,
   output logic [5:0]        maint_op,
   input  logic              maint_done,
   output logic [DATA_W-1:0] control,
   output logic [DATA_W-1:0] tbase
);

   logic [DATA_W-1:0] rf [NUM_REGS];
   state_t            state, state_next;
   logic [1:0]        gnt;
   logic              arb_en;
   maint_op_t         cpu_mop;
   logic              cpu_maint, start_maint, maint_exit, maint_fault;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
`ifdef CP15_MAINT_TIMEOUT_EN
   logic [9:0]        maint_cnt;
`endif

   // Registers beyond the architected sixteen are plain storage.
   function automatic logic [DATA_W-1:0] wmask(input int idx);
      if (idx < 16) return DATA_W'(CP15_WMASK[idx[3:0]]);
      else          return {DATA_W{1'b1}};
   endfunction

   function automatic logic [DATA_W-1:0] rmask(input int idx);
      if (idx < 16) return DATA_W'(CP15_RMASK[idx[3:0]]);
      else          return {DATA_W{1'b1}};
   endfunction

   function automatic logic [DATA_W-1:0] rst_val(input int idx);
      if (idx < 16) return DATA_W'(CP15_RESET_VAL[idx[3:0]]);
      else          return {DATA_W{1'b0}};
   endfunction

   assign arb_en = (state == IDLE);

   cp15_rr_arb u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .req   ({mmu_req, cpu_req}),
      .gnt   (gnt)
   );

   assign cpu_mop     = decode_maint(cpu_op2, cpu_crm, 32'(cpu_addr));
   assign cpu_maint   = cpu_we & (|cpu_mop);
   assign start_maint = gnt[0] & cpu_maint;

`ifdef CP15_MAINT_TIMEOUT_EN
   // maint_done on the final count still wins, so no fault is flagged then.
   assign maint_fault = (state == MAINT) & ~maint_done & (maint_cnt == 10'd1023);
`else
   assign maint_fault = 1'b0;
`endif
   assign maint_exit = (state == MAINT) & (maint_done | maint_fault);

   // maintenance sequencer next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_maint) state_next = MAINT; else state_next = IDLE;
         MAINT:   if (maint_exit)  state_next = ACK;   else state_next = MAINT;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // select the granted register write, if any
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (gnt[0] & cpu_we & ~cpu_maint) begin
         wr_en   = 1'b1;
         wr_addr = cpu_addr;
         wr_data = cpu_wdata;
      end else if (gnt[1] & mmu_we) begin
         wr_en   = 1'b1;
         wr_addr = mmu_addr;
         wr_data = mmu_wdata;
      end else begin
         wr_en   = 1'b0;
      end
   end

   // register file, handshake outputs and sequencer state
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cpu_ack     <= 1'b0;
         mmu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         mmu_rdata   <= '0;
         maint_valid <= 1'b0;
         maint_op    <= 6'b000000;
         control     <= rst_val(CTRL_REG);
         tbase       <= rst_val(TBASE_REG);
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= rst_val(i);
`ifdef CP15_MAINT_TIMEOUT_EN
         maint_cnt   <= 10'd0;
`endif
      end else begin
         state   <= state_next;
         // A maintenance write is acknowledged only when the op finishes.
         cpu_ack <= (gnt[0] & ~cpu_maint) | maint_exit;
         mmu_ack <= gnt[1];
         if (gnt[0] & ~cpu_we) cpu_rdata <= rf[cpu_addr] & rmask(int'(cpu_addr));
         if (gnt[1] & ~mmu_we) mmu_rdata <= rf[mmu_addr] & rmask(int'(mmu_addr));
         if (start_maint) begin
            maint_valid <= 1'b1;
            maint_op    <= cpu_mop;
         end else if (maint_exit) begin
            maint_valid <= 1'b0;
            maint_op    <= 6'b000000;
         end
         // One cycle behind the register file.
         control <= rf[CTRL_REG];
         tbase   <= rf[TBASE_REG];
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && wr_addr == ADDR_W'(i))
               rf[i] <= (rf[i] & ~wmask(i)) | (wr_data & wmask(i));
         end
`ifdef CP15_MAINT_TIMEOUT_EN
         // Sticky timeout flag; any write to the fault status clears it.
         if (maint_fault)
            rf[5][0] <= 1'b1;
         else if (wr_en && wr_addr == ADDR_W'(5))
            rf[5][0] <= 1'b0;
         if (state == MAINT) maint_cnt <= maint_cnt + 10'd1;
         else                maint_cnt <= 10'd0;
`endif
      end
   end

endmodule

// File: tb/tb_cp15_sysctrl.sv
// tb_cp15_sysctrl -- directed scenarios plus randomized traffic for
// cp15_sysctrl, checked every cycle against a transaction-level model.
// Define CP15_MAINT_TIMEOUT_EN for both DUT and bench to cover the timeout.
module tb_cp15_sysctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [3:0]  cpu_addr;
   logic [2:0]  cpu_op2;
   logic [3:0]  cpu_crm;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        mmu_req, mmu_we;
   logic [3:0]  mmu_addr;
   logic [31:0] mmu_wdata;
   logic        mmu_ack;
   logic [31:0] mmu_rdata;
   logic        maint_valid;
   logic [5:0]  maint_op;
   logic        maint_done;
   logic [31:0] control, tbase;

   always #5 clk = ~clk;

   cp15_sysctrl #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_op2(cpu_op2),
      .cpu_crm(cpu_crm), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mmu_req(mmu_req), .mmu_we(mmu_we), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
      .mmu_ack(mmu_ack), .mmu_rdata(mmu_rdata),
      .maint_valid(maint_valid), .maint_op(maint_op), .maint_done(maint_done),
      .control(control), .tbase(tbase)
   );

   // ---------------- reference model ----------------
   logic [31:0] mrf [16];
   bit          mmu_turn;     // MMU wins the next tie
   int          phase;        // 0 idle, 1 waiting on memory system, 2 acking
   int          mcycles;
   logic        e_cpu_ack, e_mmu_ack, e_mv;
   logic [5:0]  e_mop;
   logic [31:0] e_cpu_rd, e_mmu_rd, e_ctrl, e_tbase;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [31:0] rst_val(int i);
      case (i)
         0:       return 32'h41069265;
         1:       return 32'h00090070;
         8:       return 32'h40000000;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mask_of(int i);
      case (i)
         1:       return 32'h0000FFFF;
         2:       return 32'hFFFFC000;
         5:       return 32'h000001FF;
         default: return 32'hFFFFFFFF;
      endcase
   endfunction

   // bit weights: INVI 32, INVD 16, CLEANI 8, CLEAND 4, TLBI 2, TLBD 1
   function automatic logic [5:0] ref_decode(logic [3:0] crn, logic [2:0] op2, logic [3:0] crm);
      if (op2 > 3'd1) return 6'd0;
      if (crn == 4'd7) begin
         case (crm)
            4'd7:    return 6'd48;
            4'd5:    return 6'd32;
            4'd6:    return 6'd16;
            4'd11:   return 6'd12;
            4'd10:   return 6'd4;
            4'd15:   return 6'd60;
            4'd14:   return 6'd20;
            default: return 6'd0;
         endcase
      end
      if (crn == 4'd8) begin
         case (crm)
            4'd7:    return 6'd3;
            4'd5:    return 6'd2;
            4'd6:    return 6'd1;
            default: return 6'd0;
         endcase
      end
      return 6'd0;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_write(int a, logic [31:0] d);
      if (a == 0 || a == 7 || a == 8) return;
      mrf[a] = (mrf[a] & ~mask_of(a)) | (d & mask_of(a));
`ifdef CP15_MAINT_TIMEOUT_EN
      if (a == 5) mrf[5][0] = 1'b0;
`endif
   endtask

   // Outcome of the coming clock edge for the inputs currently driven.
   task automatic predict();
      logic [31:0] nc, nt;
      logic [5:0]  op;
      int          win;
      if (reset) begin
         for (int i = 0; i < 16; i++) mrf[i] = rst_val(i);
         mmu_turn = 1'b0; phase = 0; mcycles = 0;
         e_cpu_ack = 1'b0; e_mmu_ack = 1'b0; e_mv = 1'b0; e_mop = 6'd0;
         e_cpu_rd = 32'd0; e_mmu_rd = 32'd0;
         e_ctrl = rst_val(1); e_tbase = rst_val(2);
         return;
      end
      nc = mrf[1];
      nt = mrf[2];
      e_cpu_ack = 1'b0;
      e_mmu_ack = 1'b0;
      if (phase == 0) begin
         win = 0;
         if (cpu_req && mmu_req) win = mmu_turn ? 2 : 1;
         else if (cpu_req)       win = 1;
         else if (mmu_req)       win = 2;
         if (win != 0) mmu_turn = !mmu_turn;
         if (win == 1) begin
            op = cpu_we ? ref_decode(cpu_addr, cpu_op2, cpu_crm) : 6'd0;
            if (op != 6'd0) begin
               phase = 1; mcycles = 0; e_mv = 1'b1; e_mop = op;
            end else begin
               e_cpu_ack = 1'b1;
               if (cpu_we) model_write(int'(cpu_addr), cpu_wdata);
               else        e_cpu_rd = mrf[cpu_addr] & mask_of(int'(cpu_addr));
            end
         end else if (win == 2) begin
            e_mmu_ack = 1'b1;
            if (mmu_we) model_write(int'(mmu_addr), mmu_wdata);
            else        e_mmu_rd = mrf[mmu_addr] & mask_of(int'(mmu_addr));
         end
      end else if (phase == 1) begin
         mcycles++;
         if (maint_done) begin
            phase = 2; e_mv = 1'b0; e_cpu_ack = 1'b1;
         end
`ifdef CP15_MAINT_TIMEOUT_EN
         else if (mcycles == 1024) begin
            phase = 2; e_mv = 1'b0; e_cpu_ack = 1'b1; mrf[5][0] = 1'b1;
         end
`endif
      end else begin
         phase = 0;
      end
      e_ctrl  = nc;
      e_tbase = nt;
   endtask

   task automatic check_all();
      check("cpu_ack",   32'(cpu_ack),     32'(e_cpu_ack));
      check("mmu_ack",   32'(mmu_ack),     32'(e_mmu_ack));
      check("both_ack",  32'(cpu_ack & mmu_ack), 32'd0);
      check("cpu_rdata", cpu_rdata,        e_cpu_rd);
      check("mmu_rdata", mmu_rdata,        e_mmu_rd);
      check("maint_vld", 32'(maint_valid), 32'(e_mv));
      if (e_mv) check("maint_op", 32'(maint_op), 32'(e_mop));
      check("control",   control,          e_ctrl);
      check("tbase",     tbase,            e_tbase);
   endtask

   task automatic cyc();
      predict();
      @(posedge clk);
      #1;
      check_all();
      if (e_cpu_ack) cpu_req = 1'b0;
      if (e_mmu_ack) mmu_req = 1'b0;
   endtask

   task automatic cpu_issue(logic we, logic [3:0] a, logic [2:0] o2, logic [3:0] cm, logic [31:0] d);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_op2 = o2; cpu_crm = cm; cpu_wdata = d;
   endtask

   task automatic mmu_issue(logic we, logic [3:0] a, logic [31:0] d);
      mmu_req = 1'b1; mmu_we = we; mmu_addr = a; mmu_wdata = d;
   endtask

   task automatic wait_idle(int max);
      int n = 0;
      while ((cpu_req || mmu_req) && n < max) begin
         cyc();
         n++;
      end
      check("wait_bound", 32'(cpu_req | mmu_req), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] crm_list [8];
      int         n, vcnt;
      crm_list = '{4'd7, 4'd5, 4'd6, 4'd11, 4'd10, 4'd15, 4'd14, 4'd3};
      reset = 1'b1; maint_done = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_op2 = 3'd0; cpu_crm = 4'd0; cpu_wdata = 32'd0;
      mmu_req = 1'b0; mmu_we = 1'b0; mmu_addr = 4'd0; mmu_wdata = 32'd0;
      @(negedge clk);
      cyc(); cyc();
      reset = 1'b0;
      check("rst_control", control, 32'h00090070);

      // read r0 straight after reset
      cpu_issue(1'b0, 4'd0, 3'd0, 4'd0, 32'd0);
      cyc();
      check("r0_ack",  32'(cpu_ack), 32'd1);
      check("r0_data", cpu_rdata, 32'h41069265);
      cyc();

      // write r2, tbase follows one cycle after the ack, read back masked
      cpu_issue(1'b1, 4'd2, 3'd0, 4'd0, 32'h12345678);
      cyc();
      cyc();
      check("tbase_upd", tbase, 32'h12344000);
      cpu_issue(1'b0, 4'd2, 3'd0, 4'd0, 32'd0);
      cyc();
      check("r2_read", cpu_rdata, 32'h12344000);

      // simultaneous reads, twice, from a freshly reset pointer
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cpu_issue(1'b0, 4'd1, 3'd0, 4'd0, 32'd0);
         mmu_issue(1'b0, 4'd8, 32'd0);
         cyc();
         check("tie_cpu_first", 32'({cpu_ack, mmu_ack}), 32'd2);
         cyc();
         check("tie_mmu_second", 32'({cpu_ack, mmu_ack}), 32'd1);
      end

      // cache maintenance with an MMU read waiting behind it
      cpu_issue(1'b1, 4'd7, 3'd0, 4'd15, 32'd0);
      cyc();
      check("maint_op_all", 32'(maint_op), 32'h3C);
      mmu_issue(1'b0, 4'd3, 32'd0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("maint_hold", 32'({cpu_ack, mmu_ack, maint_valid}), 32'd1);
      end
      maint_done = 1'b1;
      cyc();
      maint_done = 1'b0;
      check("maint_cpu_ack", 32'(cpu_ack), 32'd1);
      wait_idle(6);

      // reset while a TLB op is outstanding
      cpu_issue(1'b1, 4'd3, 3'd0, 4'd0, 32'hCAFEF00D);
      cyc();
      cpu_issue(1'b1, 4'd8, 3'd1, 4'd7, 32'd0);
      cyc(); cyc();
      reset = 1'b1; cpu_req = 1'b0; mmu_req = 1'b0;
      cyc();
      reset = 1'b0;
      check("rst_mid_maint", 32'({cpu_ack, maint_valid}), 32'd0);
      cpu_issue(1'b0, 4'd3, 3'd0, 4'd0, 32'd0);
      cyc();
      check("r3_after_rst", cpu_rdata, 32'd0);
      cyc();

`ifdef CP15_MAINT_TIMEOUT_EN
      // abandoned TLB op
      cpu_issue(1'b1, 4'd8, 3'd0, 4'd5, 32'd0);
      n = 0; vcnt = 0;
      while (cpu_req && n < 1100) begin
         cyc();
         if (maint_valid) vcnt++;
         n++;
      end
      check("timeout_cycles", 32'(vcnt), 32'd1024);
      cyc();
      cpu_issue(1'b0, 4'd5, 3'd0, 4'd0, 32'd0);
      cyc();
      check("r5_fault", cpu_rdata & 32'd1, 32'd1);
      mmu_issue(1'b1, 4'd5, 32'hFFFFFFFF);
      cyc();
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (!cpu_req && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 4) == 0)
               cpu_issue(1'b1, ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8,
                         3'($urandom_range(0, 2)), crm_list[$urandom_range(0, 7)], $urandom);
            else
               cpu_issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
         end
         if (!mmu_req && $urandom_range(0, 2) == 0)
            mmu_issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
         maint_done = ($urandom_range(0, 3) == 0);
         cyc();
      end
      maint_done = 1'b1;
      wait_idle(50);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
